// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: walks each servo channel's commanded pwm width toward its
// host-written target by at most `step` per slew tick. One shared update path
// visits the channels round-robin, one per clock, after each tick.
module servo_slew_ctrl #(
    parameter int unsigned NCH        = 8,
    parameter int unsigned TICK_DIV   = 100000,
    parameter logic [7:0]  INIT_WIDTH = 8'd128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [7:0]         step,
    input  logic [8*NCH-1:0]   target_width,
    output logic [8*NCH-1:0]   pwm_width,
    output logic [NCH-1:0]     settled,
    output logic               all_settled,
    output logic               busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [CW-1:0]          ch_q, ch_d;
    logic                   busy_q, busy_d;
    logic [NCH-1:0][7:0]    width_q, width_d;
    logic [NCH-1:0][7:0]    tgt_arr;
    logic                   tick;
    logic [8:0]             cur9, tgt9, step9, diff9;
    logic [7:0]             slewed;

    assign tgt_arr = target_width;

    // Prescaler: free-runs 0..TICK_DIV-1 while enabled, parked at 0 otherwise.
    always_comb begin
        presc_d = '0;
        tick    = 1'b0;
        if (enable) begin
            tick    = (presc_q == PRE_LAST);
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Slew arithmetic for the channel currently selected by ch_q, clamped to its target.
    always_comb begin
        cur9   = {1'b0, width_q[ch_q]};
        tgt9   = {1'b0, tgt_arr[ch_q]};
        step9  = {1'b0, step};
        diff9  = '0;
        slewed = width_q[ch_q];
        if (cur9 < tgt9) begin
            diff9  = tgt9 - cur9;
            slewed = (diff9 <= step9) ? tgt_arr[ch_q] : 8'(cur9 + step9);
        end else if (cur9 > tgt9) begin
            diff9  = cur9 - tgt9;
            slewed = (diff9 <= step9) ? tgt_arr[ch_q] : 8'(cur9 - step9);
        end
    end

    // Scan sequencing: a tick starts a pass over all channels; busy mirrors the next state.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        width_d = width_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    ch_d    = '0;
                end
            end
            SCAN: begin
                width_d[ch_q] = slewed;
                if (ch_q == CH_LAST) begin
                    state_d = IDLE;
                    ch_d    = '0;
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
            end
        endcase
        busy_d = (state_d == SCAN);
    end

    // State registers with synchronous reset back to servo centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q <= {NCH{INIT_WIDTH}};
            presc_q <= '0;
            state_q <= IDLE;
            ch_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            width_q <= width_d;
            presc_q <= presc_d;
            state_q <= state_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
        end
    end

    // Per-channel settled flags compare the live width against the live target.
    always_comb begin
        settled = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            settled[i] = (width_q[i] == tgt_arr[i]);
        end
    end

    assign pwm_width   = width_q;
    assign all_settled = &settled;
    assign busy        = busy_q;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Bench for servo_slew_ctrl: a reference model computes each tick's outcome
// for all channels at once and queues it; a monitor checks the DUT every cycle.
module tb_servo_slew_ctrl;

    localparam int unsigned NCH  = 8;
    localparam int unsigned TDIV = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [7:0]            step;
    logic [NCH-1:0][7:0]   tgt;
    logic [8*NCH-1:0]      pwm_width;
    logic [NCH-1:0]        settled;
    logic                  all_settled;
    logic                  busy;

    servo_slew_ctrl #(
        .NCH        (NCH),
        .TICK_DIV   (TDIV),
        .INIT_WIDTH (8'd128)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .step         (step),
        .target_width (tgt),
        .pwm_width    (pwm_width),
        .settled      (settled),
        .all_settled  (all_settled),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int                  tick;
        logic [NCH-1:0][7:0] old_w;
        logic [NCH-1:0][7:0] new_w;
    } item_t;

    item_t               sbq[$];
    int                  vectors    = 0;
    int                  miscompares = 0;
    bit                  mon_on     = 1'b0;

    // reference model state
    logic [NCH-1:0][7:0] mw;
    int                  en_run    = 0;
    int                  scan_left = 0;

    function automatic logic [7:0] slew_one(input int cur, input int t, input int s);
        int r;
        if (t > cur) begin
            r = cur + s;
            if (r > t) r = t;
        end else begin
            r = cur - s;
            if (r < t) r = t;
        end
        return 8'(r);
    endfunction

    task automatic model_cycle();
        item_t it;
        if (rst) begin
            mw        = {NCH{8'h80}};
            en_run    = 0;
            scan_left = 0;
        end else begin
            if (scan_left > 0) scan_left--;
            if (!enable) begin
                en_run = 0;
            end else begin
                en_run++;
                if (en_run == TDIV) begin
                    en_run   = 0;
                    it.tick  = cyc;
                    it.old_w = mw;
                    for (int k = 0; k < NCH; k++)
                        mw[k] = slew_one(int'(mw[k]), int'(tgt[k]), int'(step));
                    it.new_w = mw;
                    sbq.push_back(it);
                    scan_left = NCH;
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            model_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    // inputs are only changed outside the window where the DUT samples them
    task automatic wait_idle();
        while (scan_left != 0) run(1);
    endtask

    // monitor state
    item_t               cur;
    bit                  cur_valid = 1'b0;
    logic [NCH-1:0][7:0] committed = {NCH{8'h80}};
    logic [NCH-1:0][7:0] expw;
    logic [NCH-1:0]      exp_set;
    logic                exp_busy;

    // Monitor: pops the expected pass when its scan begins and checks every cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (!cur_valid && sbq.size() > 0 && sbq[0].tick + 1 == cyc) begin
                cur       = sbq.pop_front();
                cur_valid = 1'b1;
            end
            exp_busy = cur_valid && (cyc <= cur.tick + NCH);
            for (int k = 0; k < NCH; k++) begin
                if (cur_valid)
                    expw[k] = (cyc >= cur.tick + 2 + k) ? cur.new_w[k] : cur.old_w[k];
                else
                    expw[k] = committed[k];
                exp_set[k] = (expw[k] == tgt[k]);
            end

            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, exp_busy);
            end
            vectors++;
            if (pwm_width !== expw) begin
                miscompares++;
                $display("FAIL pwm_width cyc=%0d got=%h exp=%h", cyc, pwm_width, expw);
            end
            vectors++;
            if (settled !== exp_set) begin
                miscompares++;
                $display("FAIL settled cyc=%0d got=%b exp=%b", cyc, settled, exp_set);
            end
            vectors++;
            if (all_settled !== (&exp_set)) begin
                miscompares++;
                $display("FAIL all_settled cyc=%0d got=%0b exp=%0b", cyc, all_settled, &exp_set);
            end

            if (cur_valid && cyc >= cur.tick + 1 + NCH) begin
                committed = cur.new_w;
                cur_valid = 1'b0;
            end
            if (rst) begin
                cur_valid = 1'b0;
                committed = {NCH{8'h80}};
                sbq.delete();
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    initial begin
        int guard;
        rst    = 1'b1;
        enable = 1'b1;
        step   = 8'd4;
        tgt    = {NCH{8'h80}};
        mw     = {NCH{8'h80}};
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        run(2);
        rst = 1'b0;

        // reset state, all settled, idle until first tick
        run(20);

        // ramp ch0 by 4 per tick to 0x90
        wait_idle();
        step   = 8'd4;
        tgt[0] = 8'h90;
        run(5 * TDIV);

        // clamp to target
        wait_idle();
        step   = 8'd7;
        tgt[3] = 8'h85;
        run(2 * TDIV);
        wait_idle();
        step   = 8'd4;
        tgt[5] = 8'h7A;
        run(3 * TDIV);

        // extremes, no wrap
        wait_idle();
        step   = 8'd8;
        tgt[1] = 8'hFC;
        tgt[2] = 8'h03;
        run(18 * TDIV);
        wait_idle();
        tgt[1] = 8'hFF;
        tgt[2] = 8'h00;
        run(2 * TDIV);

        // freeze, then enable low and re-enable
        wait_idle();
        step   = 8'd0;
        tgt[4] = 8'h20;
        run(5 * TDIV);
        wait_idle();
        enable = 1'b0;
        run(40);
        enable = 1'b1;
        run(40);

        // reset in the middle of a ramp, while channel 3 is being visited
        wait_idle();
        step = 8'd1;
        tgt  = {NCH{8'hC0}};
        guard = 0;
        while (scan_left != NCH && guard < 4 * TDIV) begin
            run(1);
            guard++;
        end
        vectors++;
        if (scan_left != NCH) begin
            miscompares++;
            $display("FAIL tick_wait cyc=%0d got=no_tick exp=tick", cyc);
        end
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(2 * TDIV + 8);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (scan_left == 0) begin
                if ($urandom_range(0, 7) == 0)
                    tgt[$urandom_range(0, NCH - 1)] = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 39) == 0)
                    step = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 99) == 0)
                    enable = ~enable;
            end
            run(1);
        end

        // drain: every queued pass must have been observed
        wait_idle();
        enable = 1'b0;
        run(20);
        vectors++;
        if (sbq.size() != 0 || cur_valid) begin
            miscompares++;
            $display("FAIL drain cyc=%0d got=%0d_pending exp=0_pending", cyc, sbq.size() + int'(cur_valid));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
